// File: rtl/lstm_pkg.sv
// lstm_pkg
//    Shared types and helpers for the two-layer LSTM forward sequencer.
//    state_t  : sequencer state encoding
//    lstm_max : larger of two integers (ACC phase length of a layer)
//    K1 / K2  : ACC phase lengths for the default network dimensions
package lstm_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_L1_ACC,
      S_L1_DRAIN,
      S_L1_WR,
      S_L1_CLR,
      S_L2_ACC,
      S_L2_DRAIN,
      S_L2_WR,
      S_L2_CLR,
      S_DONE
   } state_t;

   function automatic int lstm_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int TIMESTEP_DEF    = 7;
   localparam int LAYR1_INPUT_DEF = 53;
   localparam int LAYR1_CELL_DEF  = 53;
   localparam int LAYR2_CELL_DEF  = 8;

   localparam int K1 = lstm_max(LAYR1_INPUT_DEF, LAYR1_CELL_DEF);
   localparam int K2 = lstm_max(LAYR1_CELL_DEF, LAYR2_CELL_DEF);

endpackage

// File: rtl/lstm_loop_counter.sv
// lstm_loop_counter
//    Wrapping loop index 0..LIMIT-1 used for the k, cell and timestep loops.
//    clk   : clock, rising edge
//    rst   : asynchronous active-low reset
//    inc   : advance the index; wraps to 0 after LIMIT-1
//    clr   : synchronous return to 0 (wins over inc)
//    count : current index
//    last  : count is at LIMIT-1
module lstm_loop_counter #(
   parameter int WIDTH = 12,
   parameter int LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   assign last = (count == WIDTH'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/lstm_fwd_sequencer.sv
// lstm_fwd_sequencer
//    Control sequencer for the two-layer LSTM forward datapath. One start pulse
//    runs TIMESTEP timesteps; each timestep sweeps layer 1 (LAYR1_CELL cells)
//    then layer 2 (LAYR2_CELL cells). Each cell is ACC (K cycles), DRAIN, WR, CLR.
//    Optional feature macro: LSTM_SEQ_STALL_EN adds a 'stall' input that freezes
//    state and counters and masks every acc/wr/clr enable.
//
//    clk, rst              : clock, asynchronous active-low reset
//    start                 : begin a run (sampled in IDLE only)
//    busy, done            : run in progress / one-cycle completion pulse
//    acc_x_n, acc_h_n      : layer-n accumulate enables (x*W, h*U)
//    acc_clr_n             : layer-n accumulator clear
//    h_zero_n              : t=0, datapath uses 0 for previous h
//    wr_hn, wr_cn          : write h and c of the current cell
//    addr_x1 ... rd_addr_b_2 : memory addresses, valid with their enables
//
//    state      | meaning
//    -----------+-----------------------------------------------
//    IDLE       | waiting for start
//    L1_ACC     | layer-1 accumulate, k = 0..K1-1
//    L1_DRAIN   | layer-1 pipeline drain
//    L1_WR      | write layer-1 h/c of current cell
//    L1_CLR     | clear layer-1 accumulator, advance cell
//    L2_ACC     | layer-2 accumulate, k = 0..K2-1
//    L2_DRAIN   | layer-2 pipeline drain
//    L2_WR      | write layer-2 h/c of current cell
//    L2_CLR     | clear layer-2 accumulator, advance cell / timestep
//    DONE       | one-cycle done pulse
module lstm_fwd_sequencer
   import lstm_pkg::*;
#(
   parameter int TIMESTEP    = TIMESTEP_DEF,
   parameter int LAYR1_INPUT = LAYR1_INPUT_DEF,
   parameter int LAYR1_CELL  = LAYR1_CELL_DEF,
   parameter int LAYR2_CELL  = LAYR2_CELL_DEF,
   parameter int ADDR        = 12
) (
   input  logic            clk,
   input  logic            rst,
`ifdef LSTM_SEQ_STALL_EN
   input  logic            stall,
`endif
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            acc_x_1,
   output logic            acc_h_1,
   output logic            acc_x_2,
   output logic            acc_h_2,
   output logic            acc_clr_1,
   output logic            acc_clr_2,
   output logic            h_zero_1,
   output logic            h_zero_2,
   output logic            wr_h1,
   output logic            wr_c1,
   output logic            wr_h2,
   output logic            wr_c2,
   output logic [ADDR-1:0] addr_x1,
   output logic [ADDR-1:0] rd_addr_h1,
   output logic [ADDR-1:0] rd_addr_h2,
   output logic [ADDR-1:0] wr_addr_h1,
   output logic [ADDR-1:0] wr_addr_c1,
   output logic [ADDR-1:0] wr_addr_h2,
   output logic [ADDR-1:0] wr_addr_c2,
   output logic [ADDR-1:0] rd_addr_w_1,
   output logic [ADDR-1:0] rd_addr_u_1,
   output logic [ADDR-1:0] rd_addr_b_1,
   output logic [ADDR-1:0] rd_addr_w_2,
   output logic [ADDR-1:0] rd_addr_u_2,
   output logic [ADDR-1:0] rd_addr_b_2
);

   localparam int K1_LEN = lstm_max(LAYR1_INPUT, LAYR1_CELL);
   localparam int K2_LEN = lstm_max(LAYR1_CELL, LAYR2_CELL);

   localparam logic [ADDR-1:0] IN_A = ADDR'(LAYR1_INPUT);
   localparam logic [ADDR-1:0] C1_A = ADDR'(LAYR1_CELL);
   localparam logic [ADDR-1:0] C2_A = ADDR'(LAYR2_CELL);

   state_t          state;
   logic            hold;
   logic            cnt_clr;
   logic            k1_inc, k2_inc, cell1_inc, cell2_inc, t_inc;
   logic            k1_last, k2_last, cell1_last, cell2_last, t_last;
   logic [ADDR-1:0] k1, k2, cell1, cell2, t;

   // Running products kept as registers so no multiplier is needed:
   // base_* = t*N, prev_* = (t-1)*N, base_w/u = cell*N.
   logic [ADDR-1:0] base_x1, base_h1, prev_h1, base_h2, prev_h2;
   logic [ADDR-1:0] base_w1, base_u1, base_w2, base_u2;

`ifdef LSTM_SEQ_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   assign cnt_clr   = (state == S_IDLE);
   assign k1_inc    = !hold && (state == S_L1_ACC);
   assign k2_inc    = !hold && (state == S_L2_ACC);
   assign cell1_inc = !hold && (state == S_L1_CLR);
   assign cell2_inc = !hold && (state == S_L2_CLR);
   assign t_inc     = cell2_inc && cell2_last;

   lstm_loop_counter #(.WIDTH(ADDR), .LIMIT(K1_LEN)) u_k1 (
      .clk(clk), .rst(rst), .inc(k1_inc), .clr(cnt_clr), .count(k1), .last(k1_last)
   );
   lstm_loop_counter #(.WIDTH(ADDR), .LIMIT(K2_LEN)) u_k2 (
      .clk(clk), .rst(rst), .inc(k2_inc), .clr(cnt_clr), .count(k2), .last(k2_last)
   );
   lstm_loop_counter #(.WIDTH(ADDR), .LIMIT(LAYR1_CELL)) u_cell1 (
      .clk(clk), .rst(rst), .inc(cell1_inc), .clr(cnt_clr), .count(cell1), .last(cell1_last)
   );
   lstm_loop_counter #(.WIDTH(ADDR), .LIMIT(LAYR2_CELL)) u_cell2 (
      .clk(clk), .rst(rst), .inc(cell2_inc), .clr(cnt_clr), .count(cell2), .last(cell2_last)
   );
   lstm_loop_counter #(.WIDTH(ADDR), .LIMIT(TIMESTEP)) u_t (
      .clk(clk), .rst(rst), .inc(t_inc), .clr(cnt_clr), .count(t), .last(t_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         base_x1 <= '0;
         base_h1 <= '0;
         prev_h1 <= '0;
         base_h2 <= '0;
         prev_h2 <= '0;
         base_w1 <= '0;
         base_u1 <= '0;
         base_w2 <= '0;
         base_u2 <= '0;
      end else if (!hold) begin
         case (state)
            S_IDLE:     if (start) state <= S_L1_ACC;
            S_L1_ACC:   if (k1_last) state <= S_L1_DRAIN;
            S_L1_DRAIN: state <= S_L1_WR;
            S_L1_WR:    state <= S_L1_CLR;
            S_L1_CLR:   state <= cell1_last ? S_L2_ACC : S_L1_ACC;
            S_L2_ACC:   if (k2_last) state <= S_L2_DRAIN;
            S_L2_DRAIN: state <= S_L2_WR;
            S_L2_WR:    state <= S_L2_CLR;
            S_L2_CLR: begin
               if (!cell2_last)  state <= S_L2_ACC;
               else if (t_last)  state <= S_DONE;
               else              state <= S_L1_ACC;
            end
            S_DONE:     state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase

         if (cell1_inc) begin
            base_w1 <= cell1_last ? '0 : base_w1 + IN_A;
            base_u1 <= cell1_last ? '0 : base_u1 + C1_A;
         end
         if (cell2_inc) begin
            base_w2 <= cell2_last ? '0 : base_w2 + C1_A;
            base_u2 <= cell2_last ? '0 : base_u2 + C2_A;
         end
         // Last timestep wraps every t-based product back to 0 so DONE/IDLE
         // present all-zero addresses.
         if (t_inc) begin
            if (t_last) begin
               base_x1 <= '0;
               base_h1 <= '0;
               prev_h1 <= '0;
               base_h2 <= '0;
               prev_h2 <= '0;
            end else begin
               base_x1 <= base_x1 + IN_A;
               prev_h1 <= base_h1;
               base_h1 <= base_h1 + C1_A;
               prev_h2 <= base_h2;
               base_h2 <= base_h2 + C2_A;
            end
         end
      end
   end

   logic in_l1, in_l2, t_zero, en;

   assign in_l1  = (state == S_L1_ACC) || (state == S_L1_DRAIN) ||
                   (state == S_L1_WR)  || (state == S_L1_CLR);
   assign in_l2  = (state == S_L2_ACC) || (state == S_L2_DRAIN) ||
                   (state == S_L2_WR)  || (state == S_L2_CLR);
   assign t_zero = (t == '0);
   assign en     = !hold;

   assign busy      = in_l1 || in_l2;
   assign done      = (state == S_DONE);
   assign acc_x_1   = en && (state == S_L1_ACC) && (k1 < IN_A);
   assign acc_h_1   = en && (state == S_L1_ACC) && (k1 < C1_A);
   assign acc_x_2   = en && (state == S_L2_ACC) && (k2 < C1_A);
   assign acc_h_2   = en && (state == S_L2_ACC) && (k2 < C2_A);
   assign acc_clr_1 = en && (state == S_L1_CLR);
   assign acc_clr_2 = en && (state == S_L2_CLR);
   assign wr_h1     = en && (state == S_L1_WR);
   assign wr_c1     = en && (state == S_L1_WR);
   assign wr_h2     = en && (state == S_L2_WR);
   assign wr_c2     = en && (state == S_L2_WR);
   assign h_zero_1  = in_l1 && t_zero;
   assign h_zero_2  = in_l2 && t_zero;

   // rd_addr_h1 is shared: layer-1 recurrent read, then layer-2 input read.
   assign addr_x1     = base_x1 + k1;
   assign rd_addr_h1  = in_l2                ? base_h1 + k2 :
                        (in_l1 && !t_zero)   ? prev_h1 + k1 : '0;
   assign rd_addr_h2  = (in_l2 && !t_zero)   ? prev_h2 + k2 : '0;
   assign wr_addr_h1  = base_h1 + cell1;
   assign wr_addr_c1  = base_h1 + cell1;
   assign wr_addr_h2  = base_h2 + cell2;
   assign wr_addr_c2  = base_h2 + cell2;
   assign rd_addr_w_1 = base_w1 + k1;
   assign rd_addr_u_1 = base_u1 + k1;
   assign rd_addr_b_1 = cell1;
   assign rd_addr_w_2 = base_w2 + k2;
   assign rd_addr_u_2 = base_u2 + k2;
   assign rd_addr_b_2 = cell2;

endmodule

// File: tb/tb_lstm_fwd_sequencer.sv
module tb_lstm_fwd_sequencer;

   localparam int AW  = 12;
   localparam int ST  = 2;
   localparam int SIN = 3;
   localparam int SC1 = 2;
   localparam int SC2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_s, start_d;
`ifdef LSTM_SEQ_STALL_EN
   logic stall_s, stall_d;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   logic s_busy, s_done, s_ax1, s_ah1, s_ax2, s_ah2, s_clr1, s_clr2;
   logic s_hz1, s_hz2, s_wh1, s_wc1, s_wh2, s_wc2;
   logic [AW-1:0] s_x1, s_rdh1, s_rdh2, s_wah1, s_wac1, s_wah2, s_wac2;
   logic [AW-1:0] s_w1, s_u1, s_b1, s_w2, s_u2, s_b2;

   logic d_busy, d_done, d_ax1, d_ah1, d_ax2, d_ah2, d_clr1, d_clr2;
   logic d_hz1, d_hz2, d_wh1, d_wc1, d_wh2, d_wc2;
   logic [AW-1:0] d_x1, d_rdh1, d_rdh2, d_wah1, d_wac1, d_wah2, d_wac2;
   logic [AW-1:0] d_w1, d_u1, d_b1, d_w2, d_u2, d_b2;

   lstm_fwd_sequencer #(
      .TIMESTEP(ST), .LAYR1_INPUT(SIN), .LAYR1_CELL(SC1), .LAYR2_CELL(SC2), .ADDR(AW)
   ) dut_s (
      .clk(clk), .rst(rst),
`ifdef LSTM_SEQ_STALL_EN
      .stall(stall_s),
`endif
      .start(start_s), .busy(s_busy), .done(s_done),
      .acc_x_1(s_ax1), .acc_h_1(s_ah1), .acc_x_2(s_ax2), .acc_h_2(s_ah2),
      .acc_clr_1(s_clr1), .acc_clr_2(s_clr2), .h_zero_1(s_hz1), .h_zero_2(s_hz2),
      .wr_h1(s_wh1), .wr_c1(s_wc1), .wr_h2(s_wh2), .wr_c2(s_wc2),
      .addr_x1(s_x1), .rd_addr_h1(s_rdh1), .rd_addr_h2(s_rdh2),
      .wr_addr_h1(s_wah1), .wr_addr_c1(s_wac1), .wr_addr_h2(s_wah2), .wr_addr_c2(s_wac2),
      .rd_addr_w_1(s_w1), .rd_addr_u_1(s_u1), .rd_addr_b_1(s_b1),
      .rd_addr_w_2(s_w2), .rd_addr_u_2(s_u2), .rd_addr_b_2(s_b2)
   );

   lstm_fwd_sequencer dut_d (
      .clk(clk), .rst(rst),
`ifdef LSTM_SEQ_STALL_EN
      .stall(stall_d),
`endif
      .start(start_d), .busy(d_busy), .done(d_done),
      .acc_x_1(d_ax1), .acc_h_1(d_ah1), .acc_x_2(d_ax2), .acc_h_2(d_ah2),
      .acc_clr_1(d_clr1), .acc_clr_2(d_clr2), .h_zero_1(d_hz1), .h_zero_2(d_hz2),
      .wr_h1(d_wh1), .wr_c1(d_wc1), .wr_h2(d_wh2), .wr_c2(d_wc2),
      .addr_x1(d_x1), .rd_addr_h1(d_rdh1), .rd_addr_h2(d_rdh2),
      .wr_addr_h1(d_wah1), .wr_addr_c1(d_wac1), .wr_addr_h2(d_wah2), .wr_addr_c2(d_wac2),
      .rd_addr_w_1(d_w1), .rd_addr_u_1(d_u1), .rd_addr_b_1(d_b1),
      .rd_addr_w_2(d_w2), .rd_addr_u_2(d_u2), .rd_addr_b_2(d_b2)
   );

   // ctrl bits: 13 busy,12 done,11 ax1,10 ah1,9 ax2,8 ah2,7 clr1,6 clr2,
   //            5 hz1,4 hz2,3 wh1,2 wc1,1 wh2,0 wc2
   logic [13:0] s_ctrl;
   assign s_ctrl = {s_busy, s_done, s_ax1, s_ah1, s_ax2, s_ah2, s_clr1, s_clr2,
                    s_hz1, s_hz2, s_wh1, s_wc1, s_wh2, s_wc2};

   logic [AW-1:0] s_addr_or;
   assign s_addr_or = s_x1 | s_rdh1 | s_rdh2 | s_wah1 | s_wac1 | s_wah2 | s_wac2 |
                      s_w1 | s_u1 | s_b1 | s_w2 | s_u2 | s_b2;

   typedef struct packed {
      logic [13:0]   ctrl;
      logic [AW-1:0] x1, rdh1, rdh2, wah1, wah2, w1, u1, b1, w2, u2, b2;
   } exp_t;

   exp_t sbq[$];

   logic [13:0]   log_ctrl [0:63];
   logic [AW-1:0] log_rdh1 [0:63];
   logic [AW-1:0] log_wah1 [0:63];

   typedef struct {
      string         name;
      int            cyc;
      logic          ax, ah, hz, wh;
      logic [AW-1:0] rdh1, wah1;
      bit            chk_rd, chk_wa;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Independent cycle-by-cycle model of one small-parameter run.
   task automatic push_run();
      exp_t e;
      int   k1 = (SIN > SC1) ? SIN : SC1;
      int   k2 = (SC1 > SC2) ? SC1 : SC2;
      for (int t = 0; t < ST; t++) begin
         for (int c = 0; c < SC1; c++) begin
            for (int ph = 0; ph < k1 + 3; ph++) begin
               e = '0;
               e.ctrl[13] = 1'b1;
               e.ctrl[5]  = (t == 0);
               if (ph < k1) begin
                  e.ctrl[11] = (ph < SIN);
                  e.ctrl[10] = (ph < SC1);
                  e.x1   = AW'(t * SIN + ph);
                  e.w1   = AW'(c * SIN + ph);
                  e.rdh1 = (t == 0) ? '0 : AW'((t - 1) * SC1 + ph);
                  e.u1   = AW'(c * SC1 + ph);
                  e.b1   = AW'(c);
               end else if (ph == k1 + 1) begin
                  e.ctrl[3] = 1'b1;
                  e.ctrl[2] = 1'b1;
                  e.wah1    = AW'(t * SC1 + c);
               end else if (ph == k1 + 2) begin
                  e.ctrl[7] = 1'b1;
               end
               sbq.push_back(e);
            end
         end
         for (int c = 0; c < SC2; c++) begin
            for (int ph = 0; ph < k2 + 3; ph++) begin
               e = '0;
               e.ctrl[13] = 1'b1;
               e.ctrl[4]  = (t == 0);
               if (ph < k2) begin
                  e.ctrl[9] = (ph < SC1);
                  e.ctrl[8] = (ph < SC2);
                  e.rdh1 = AW'(t * SC1 + ph);
                  e.w2   = AW'(c * SC1 + ph);
                  e.rdh2 = (t == 0) ? '0 : AW'((t - 1) * SC2 + ph);
                  e.u2   = AW'(c * SC2 + ph);
                  e.b2   = AW'(c);
               end else if (ph == k2 + 1) begin
                  e.ctrl[1] = 1'b1;
                  e.ctrl[0] = 1'b1;
                  e.wah2    = AW'(t * SC2 + c);
               end else if (ph == k2 + 2) begin
                  e.ctrl[6] = 1'b1;
               end
               sbq.push_back(e);
            end
         end
      end
      e = '0;
      e.ctrl[12] = 1'b1;
      sbq.push_back(e);
      e = '0;
      sbq.push_back(e);
   endtask

   // mode 0: start pulse; 1: start held high until done; 2: extra pulse mid-run
   task automatic run_small(input int mode, input string tag);
      exp_t e;
      int   cyc = 0;
      push_run();
      @(negedge clk);
      start_s = 1'b1;
      while (sbq.size() > 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mode == 0) start_s = 1'b0;
         if (mode == 2) start_s = (cyc == 20);
         e = sbq.pop_front();
         if (e.ctrl[12]) start_s = 1'b0;
         if (cyc <= 64) begin
            log_ctrl[cyc-1] = s_ctrl;
            log_rdh1[cyc-1] = s_rdh1;
            log_wah1[cyc-1] = s_wah1;
         end
         chk({tag, "_ctrl"}, 32'(s_ctrl), 32'(e.ctrl));
         if (e.ctrl[11]) begin
            chk({tag, "_addr_x1"}, 32'(s_x1), 32'(e.x1));
            chk({tag, "_w1"}, 32'(s_w1), 32'(e.w1));
            chk({tag, "_b1"}, 32'(s_b1), 32'(e.b1));
         end
         if (e.ctrl[10]) begin
            chk({tag, "_rdh1_l1"}, 32'(s_rdh1), 32'(e.rdh1));
            chk({tag, "_u1"}, 32'(s_u1), 32'(e.u1));
         end
         if (e.ctrl[9]) begin
            chk({tag, "_rdh1_l2"}, 32'(s_rdh1), 32'(e.rdh1));
            chk({tag, "_w2"}, 32'(s_w2), 32'(e.w2));
            chk({tag, "_b2"}, 32'(s_b2), 32'(e.b2));
         end
         if (e.ctrl[8]) begin
            chk({tag, "_rdh2"}, 32'(s_rdh2), 32'(e.rdh2));
            chk({tag, "_u2"}, 32'(s_u2), 32'(e.u2));
         end
         if (e.ctrl[3]) begin
            chk({tag, "_wah1"}, 32'(s_wah1), 32'(e.wah1));
            chk({tag, "_wac1"}, 32'(s_wac1), 32'(e.wah1));
         end
         if (e.ctrl[1]) begin
            chk({tag, "_wah2"}, 32'(s_wah2), 32'(e.wah2));
            chk({tag, "_wac2"}, 32'(s_wac2), 32'(e.wah2));
         end
      end
      chk({tag, "_queue_drained"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
      start_s = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk({tag, "_stays_idle"}, 32'({s_busy, s_done}), 32'd0);
      end
   endtask

   task automatic run_default();
      logic [AW-1:0] qa1[$];
      logic [AW-1:0] qa2[$];
      logic [AW-1:0] last_wa2 = '0;
      int busy_cnt = 0;
      int cyc      = 0;
      bit seen     = 1'b0;
      for (int t = 0; t < 7; t++) begin
         for (int c = 0; c < 53; c++) qa1.push_back(AW'(t * 53 + c));
         for (int c = 0; c < 8; c++)  qa2.push_back(AW'(t * 8 + c));
      end
      @(negedge clk);
      start_d = 1'b1;
      while (!seen && cyc < 30000) begin
         @(negedge clk);
         start_d = 1'b0;
         cyc++;
         if (d_done) seen = 1'b1;
         if (d_busy) busy_cnt++;
         if (d_wh1) begin
            if (qa1.size() > 0) chk("dflt_wr_addr_h1", 32'(d_wah1), 32'(qa1.pop_front()));
            else chk("dflt_extra_wr_h1", 32'd1, 32'd0);
         end
         if (d_wh2) begin
            last_wa2 = d_wah2;
            if (qa2.size() > 0) chk("dflt_wr_addr_h2", 32'(d_wah2), 32'(qa2.pop_front()));
            else chk("dflt_extra_wr_h2", 32'd1, 32'd0);
         end
      end
      chk("dflt_done_seen", 32'(seen), 32'd1);
      chk("dflt_busy_cycles", 32'(busy_cnt), 32'd23912);
      chk("dflt_last_wr_addr_h2", 32'(last_wa2), 32'd55);
      chk("dflt_wr_h1_count", 32'(qa1.size()), 32'd0);
      chk("dflt_wr_h2_count", 32'(qa2.size()), 32'd0);
   endtask

`ifdef LSTM_SEQ_STALL_EN
   task automatic run_stall();
      int busy_cnt = 0;
      int cyc      = 0;
      bit seen     = 1'b0;
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      busy_cnt += int'(s_busy);
      repeat (4) begin
         @(negedge clk);
         busy_cnt += int'(s_busy);
      end
      stall_s = 1'b1;
      #1;
      chk("stall_wr_masked", 32'(s_wh1), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         busy_cnt += int'(s_busy);
         chk("stall_wr_low", 32'(s_wh1), 32'd0);
      end
      stall_s = 1'b0;
      #1;
      chk("stall_resume_wr", 32'(s_wh1), 32'd1);
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("stall_single_wr_pulse", 32'({s_wh1, s_clr1}), 32'd1);
         if (s_done) seen = 1'b1;
         else busy_cnt += int'(s_busy);
      end
      chk("stall_done_seen", 32'(seen), 32'd1);
      chk("stall_busy_cycles", 32'(busy_cnt), 32'd49);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy_cnt;

      tbl[0] = '{"t0c0_k0",  0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0};
      tbl[1] = '{"t0c0_k1",  1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0};
      tbl[2] = '{"t0c0_k2",  2, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
      tbl[3] = '{"t0c0_drn", 3, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
      tbl[4] = '{"t0c0_wr",  4, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b1};
      tbl[5] = '{"t1c1_k0", 28, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0};
      tbl[6] = '{"t1c1_k1", 29, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd0, 1'b1, 1'b0};
      tbl[7] = '{"t1c1_k2", 30, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
      tbl[8] = '{"t1c1_wr", 32, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd3, 1'b0, 1'b1};

      rst     = 1'b0;
      start_s = 1'b0;
      start_d = 1'b0;
`ifdef LSTM_SEQ_STALL_EN
      stall_s = 1'b0;
      stall_d = 1'b0;
`endif
      #1;
      chk("reset_ctrl", 32'(s_ctrl), 32'd0);
      chk("reset_addr", 32'(s_addr_or), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      run_small(0, "pulse");

      for (int i = 0; i < 9; i++) begin
         chk({tbl[i].name, "_acc_x_1"}, 32'(log_ctrl[tbl[i].cyc][11]), 32'(tbl[i].ax));
         chk({tbl[i].name, "_acc_h_1"}, 32'(log_ctrl[tbl[i].cyc][10]), 32'(tbl[i].ah));
         chk({tbl[i].name, "_h_zero_1"}, 32'(log_ctrl[tbl[i].cyc][5]), 32'(tbl[i].hz));
         chk({tbl[i].name, "_wr_h1"}, 32'(log_ctrl[tbl[i].cyc][3]), 32'(tbl[i].wh));
         if (tbl[i].chk_rd)
            chk({tbl[i].name, "_rd_addr_h1"}, 32'(log_rdh1[tbl[i].cyc]), 32'(tbl[i].rdh1));
         if (tbl[i].chk_wa)
            chk({tbl[i].name, "_wr_addr_h1"}, 32'(log_wah1[tbl[i].cyc]), 32'(tbl[i].wah1));
      end

      busy_cnt = 0;
      for (int i = 0; i < 46; i++) busy_cnt += int'(log_ctrl[i][13]);
      chk("small_busy_cycles", 32'(busy_cnt), 32'd44);
      chk("small_done_cycle45", 32'(log_ctrl[44][12]), 32'd1);

      run_small(1, "held");
      run_small(2, "midpulse");

      // reset during L2_ACC
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (12) @(negedge clk);
      chk("rst_pre_l2_acc", 32'(s_ax2), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_ctrl", 32'(s_ctrl), 32'd0);
      chk("rst_mid_addr", 32'(s_addr_or), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_no_done", 32'({s_busy, s_done}), 32'd0);
      end
      run_small(0, "after_rst");

      run_default();

`ifdef LSTM_SEQ_STALL_EN
      run_stall();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
